icache_ctrl: RTL and testbench

Initiator and controller for the icache_line tag/valid/data array. It sits between the IFU fetch port and the memory bus. On each fetch it looks up the line, returns the 32-bit instruction on a hit, and on a miss runs a 4-beat burst refill that it writes back through the CEN/WEN/BWEN/A/D port. It drives every input of the line array and consumes its valid, tag and Q outputs.

---
 rtl/icache_ctrl_pkg.sv | 21 ++
 rtl/icache_refill_buf.sv | 36 +++
 rtl/icache_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_icache_ctrl.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/icache_ctrl_pkg.sv
// icache_ctrl_pkg: shared state encodings and line geometry for the icache controller.
// Contents:
//   state_e             controller FSM states
//   ICACHE_OFFSET_W     byte-offset width inside one line
//   ICACHE_BURST_BEATS  32-bit beats per line refill
//   LINE_W              line width in bits
package icache_ctrl_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLookup,
    StMissAr,
    StMissR,
    StRefill
  } state_e;

  localparam int unsigned ICACHE_OFFSET_W    = 4;
  localparam int unsigned ICACHE_BURST_BEATS = 4;
  localparam int unsigned LINE_W             = 32 * ICACHE_BURST_BEATS;

endpackage

// File: rtl/icache_refill_buf.sv
// icache_refill_buf: collects the four 32-bit refill beats into one 128-bit line.
// Ports:
//   i_clk, i_rst_n   clock, asynchronous active-low reset
//   i_clear          restart assembly at word 0
//   i_beat_valid     accept i_rdata into the current word, then advance
//   i_rdata          beat data
//   o_line           assembled line, beat 0 in [31:0]
module icache_refill_buf
  import icache_ctrl_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_clear,
  input  logic              i_beat_valid,
  input  logic [31:0]       i_rdata,
  output logic [LINE_W-1:0] o_line
);

  logic [1:0]        r_beat_cnt;
  logic [LINE_W-1:0] r_line;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_beat_cnt <= 2'd0;
      r_line     <= '0;
    end else if (i_clear) begin
      r_beat_cnt <= 2'd0;
    end else if (i_beat_valid) begin
      r_line[{r_beat_cnt, 5'b0} +: 32] <= i_rdata;
      r_beat_cnt                       <= r_beat_cnt + 2'd1;
    end
  end

  assign o_line = r_line;

endmodule

// File: rtl/icache_ctrl.sv
// icache_ctrl: fetch-side controller for the icache_line tag/valid/data array.
// Looks up each IFU fetch, answers hits from the array, refills misses with a 4-beat
// burst and writes the refilled line back into the array.
// Ports:
//   i_clk, i_rst_n                 clock, asynchronous active-low reset
//   i_ifu_*, o_ifu_*               fetch request / flush / one-cycle response
//   o_mem_ar*, i_mem_arready       burst address handshake (line aligned)
//   i_mem_r*, o_mem_rready         burst read data
//   o_line_*, i_line_*             array control, write data, registered valid/tag/Q
//   o_perf_hit_cnt, o_perf_miss_cnt  only when ICACHE_PERF_CNT_EN is defined
// Optional feature macro: ICACHE_PERF_CNT_EN (hit/miss performance counters).
module icache_ctrl
  import icache_ctrl_pkg::*;
#(
  parameter int unsigned DATA_LEN = 32,
  parameter int unsigned SRAM_NUM = 1,
  parameter int unsigned TAG_LEN  = DATA_LEN - 10 - $clog2(SRAM_NUM),
  parameter int unsigned ADDR_LEN = 6 + $clog2(SRAM_NUM)
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_ifu_req_valid,
  output logic                o_ifu_req_ready,
  input  logic [DATA_LEN-1:0] i_ifu_addr,
  input  logic                i_ifu_flush,
  output logic                o_ifu_rsp_valid,
  output logic [31:0]         o_ifu_rsp_data,
  output logic                o_mem_arvalid,
  input  logic                i_mem_arready,
  output logic [DATA_LEN-1:0] o_mem_araddr,
  input  logic                i_mem_rvalid,
  output logic                o_mem_rready,
  input  logic [31:0]         i_mem_rdata,
  input  logic                i_mem_rlast,
  output logic [TAG_LEN-1:0]  o_line_tag_in,
  output logic                o_line_addr_valid,
  input  logic                i_line_valid,
  input  logic [TAG_LEN-1:0]  i_line_tag,
  input  logic [LINE_W-1:0]   i_line_Q,
  output logic                o_line_CEN,
  output logic                o_line_WEN,
  output logic [LINE_W-1:0]   o_line_BWEN,
  output logic [ADDR_LEN-1:0] o_line_A,
  output logic [LINE_W-1:0]   o_line_D
`ifdef ICACHE_PERF_CNT_EN
  ,
  output logic [31:0]         o_perf_hit_cnt,
  output logic [31:0]         o_perf_miss_cnt
`endif
);

  state_e                r_state;
  logic [DATA_LEN-1:0]   r_addr;
  logic                  r_drop;
  logic                  r_hit_rsp;
  logic [31:0]           r_hit_data;
  logic                  r_arvalid;
  logic                  r_rready;

  logic [ADDR_LEN-1:0]   w_req_idx;
  logic [TAG_LEN-1:0]    w_req_tag;
  logic [1:0]            w_word;
  logic                  w_accept;
  logic                  w_hit;
  logic                  w_refill_rsp;
  logic [LINE_W-1:0]     w_buf;
  logic                  w_unused_addr;

  assign w_req_idx     = r_addr[ADDR_LEN+ICACHE_OFFSET_W-1:ICACHE_OFFSET_W];
  assign w_req_tag     = r_addr[DATA_LEN-1:ADDR_LEN+ICACHE_OFFSET_W];
  assign w_word        = r_addr[3:2];
  assign w_unused_addr = ^r_addr[1:0];
  assign w_accept      = (r_state == StIdle) && i_ifu_req_valid;
  assign w_hit         = i_line_valid && (i_line_tag == w_req_tag);

  icache_refill_buf u_refill_buf (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_clear      (r_state == StMissAr),
    .i_beat_valid (r_state == StMissR && i_mem_rvalid),
    .i_rdata      (i_mem_rdata),
    .o_line       (w_buf)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= StIdle;
      r_addr     <= '0;
      r_drop     <= 1'b0;
      r_hit_rsp  <= 1'b0;
      r_hit_data <= '0;
      r_arvalid  <= 1'b0;
      r_rready   <= 1'b0;
    end else begin
      r_hit_rsp <= 1'b0;
      unique case (r_state)
        StIdle: begin
          r_drop <= 1'b0;
          // A flush in the acceptance cycle targets the previous fetch, not this one.
          if (i_ifu_req_valid) begin
            r_addr  <= i_ifu_addr;
            r_state <= StLookup;
          end
        end
        StLookup: begin
          if (i_ifu_flush) begin
            r_state <= StIdle;
          end else if (w_hit) begin
            r_hit_rsp  <= 1'b1;
            r_hit_data <= i_line_Q[{w_word, 5'b0} +: 32];
            r_state    <= StIdle;
          end else begin
            r_arvalid <= 1'b1;
            r_state   <= StMissAr;
          end
        end
        StMissAr: begin
          if (i_ifu_flush) r_drop <= 1'b1;
          if (i_mem_arready) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
            r_state   <= StMissR;
          end
        end
        StMissR: begin
          if (i_ifu_flush) r_drop <= 1'b1;
          // rlast ends the burst regardless of how many beats were counted.
          if (i_mem_rvalid && i_mem_rlast) begin
            r_rready <= 1'b0;
            r_state  <= StRefill;
          end
        end
        StRefill: begin
          if (i_ifu_flush) r_drop <= 1'b1;
          r_state <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  // The read strobe must reach the array in the acceptance cycle so valid/tag/Q are
  // registered by the time LOOKUP evaluates the hit; hence the array port is decoded here.
  always_comb begin
    o_line_CEN        = 1'b1;
    o_line_WEN        = 1'b1;
    o_line_BWEN       = '1;
    o_line_A          = w_req_idx;
    o_line_D          = w_buf;
    o_line_tag_in     = w_req_tag;
    o_line_addr_valid = 1'b0;
    if (w_accept) begin
      o_line_CEN        = 1'b0;
      o_line_A          = i_ifu_addr[ADDR_LEN+ICACHE_OFFSET_W-1:ICACHE_OFFSET_W];
      o_line_addr_valid = 1'b1;
    end
    if (r_state == StRefill) begin
      o_line_CEN  = 1'b0;
      o_line_WEN  = 1'b0;
      o_line_BWEN = '0;
    end
  end

  // A flush arriving in REFILL itself still kills the response.
  assign w_refill_rsp    = (r_state == StRefill) && !r_drop && !i_ifu_flush;
  assign o_ifu_req_ready = (r_state == StIdle);
  assign o_ifu_rsp_valid = r_hit_rsp || w_refill_rsp;
  assign o_ifu_rsp_data  = w_refill_rsp ? w_buf[{w_word, 5'b0} +: 32] : r_hit_data;
  assign o_mem_arvalid   = r_arvalid;
  assign o_mem_araddr    = {r_addr[DATA_LEN-1:ICACHE_OFFSET_W], {ICACHE_OFFSET_W{1'b0}}};
  assign o_mem_rready    = r_rready;

`ifdef ICACHE_PERF_CNT_EN
  logic [31:0] r_perf_hit_cnt;
  logic [31:0] r_perf_miss_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_perf_hit_cnt  <= '0;
      r_perf_miss_cnt <= '0;
    end else if (r_state == StLookup && !i_ifu_flush) begin
      if (w_hit) r_perf_hit_cnt  <= r_perf_hit_cnt + 32'd1;
      else       r_perf_miss_cnt <= r_perf_miss_cnt + 32'd1;
    end
  end

  assign o_perf_hit_cnt  = r_perf_hit_cnt;
  assign o_perf_miss_cnt = r_perf_miss_cnt;
`endif

endmodule

// File: tb/tb_icache_ctrl.sv
// tb_icache_ctrl: directed bench for icache_ctrl with a behavioural icache_line array.
module tb_icache_ctrl;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         ifu_req_valid, ifu_req_ready, ifu_flush, ifu_rsp_valid;
  logic [31:0]  ifu_addr, ifu_rsp_data;
  logic         mem_arvalid, mem_arready, mem_rvalid, mem_rready, mem_rlast;
  logic [31:0]  mem_araddr, mem_rdata;
  logic [21:0]  line_tag_in, line_tag;
  logic         line_addr_valid, line_valid, line_CEN, line_WEN;
  logic [127:0] line_Q, line_BWEN, line_D;
  logic [5:0]   line_A;
`ifdef ICACHE_PERF_CNT_EN
  logic [31:0]  perf_hit_cnt, perf_miss_cnt;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  icache_ctrl dut (
    .i_clk             (clk),
    .i_rst_n           (rst_n),
    .i_ifu_req_valid   (ifu_req_valid),
    .o_ifu_req_ready   (ifu_req_ready),
    .i_ifu_addr        (ifu_addr),
    .i_ifu_flush       (ifu_flush),
    .o_ifu_rsp_valid   (ifu_rsp_valid),
    .o_ifu_rsp_data    (ifu_rsp_data),
    .o_mem_arvalid     (mem_arvalid),
    .i_mem_arready     (mem_arready),
    .o_mem_araddr      (mem_araddr),
    .i_mem_rvalid      (mem_rvalid),
    .o_mem_rready      (mem_rready),
    .i_mem_rdata       (mem_rdata),
    .i_mem_rlast       (mem_rlast),
    .o_line_tag_in     (line_tag_in),
    .o_line_addr_valid (line_addr_valid),
    .i_line_valid      (line_valid),
    .i_line_tag        (line_tag),
    .i_line_Q          (line_Q),
    .o_line_CEN        (line_CEN),
    .o_line_WEN        (line_WEN),
    .o_line_BWEN       (line_BWEN),
    .o_line_A          (line_A),
    .o_line_D          (line_D)
`ifdef ICACHE_PERF_CNT_EN
    ,
    .o_perf_hit_cnt    (perf_hit_cnt),
    .o_perf_miss_cnt   (perf_miss_cnt)
`endif
  );

  // Behavioural line array: read latches valid/tag/Q, write stores data, tag, valid.
  logic [127:0] m_data  [64];
  logic [21:0]  m_tag   [64];
  logic         m_valid [64];
  logic [127:0] q_reg;

  initial begin
    for (int i = 0; i < 64; i++) m_valid[i] = 1'b0;
    q_reg      = '0;
    line_valid = 1'b0;
    line_tag   = '0;
  end

  always @(posedge clk) begin
    if (!line_CEN) begin
      if (!line_WEN) begin
        m_data[line_A]  <= (m_data[line_A] & line_BWEN) | (line_D & ~line_BWEN);
        m_tag[line_A]   <= line_tag_in;
        m_valid[line_A] <= 1'b1;
      end else if (line_addr_valid) begin
        q_reg      <= m_data[line_A];
        line_valid <= m_valid[line_A];
        line_tag   <= m_tag[line_A];
      end
    end
  end

  assign line_Q = line_CEN ? q_reg : '0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Present a fetch in IDLE, check the array read strobe, advance into LOOKUP.
  task automatic fetch(input logic [31:0] addr, input logic [5:0] idx);
    ifu_req_valid = 1'b1;
    ifu_addr      = addr;
    #1;
    chk("accept_ready", ifu_req_ready, 1'b1);
    chk("accept_cen", line_CEN, 1'b0);
    chk("accept_av", line_addr_valid, 1'b1);
    chk("accept_a", line_A, idx);
    cyc();
    ifu_req_valid = 1'b0;
    #1;
  endtask

  task automatic beat(input logic [31:0] data, input logic last, input logic flush);
    mem_rvalid = 1'b1;
    mem_rdata  = data;
    mem_rlast  = last;
    ifu_flush  = flush;
    cyc();
    mem_rvalid = 1'b0;
    mem_rlast  = 1'b0;
    ifu_flush  = 1'b0;
    #1;
  endtask

  // LOOKUP has missed: check MISS_AR, grant the address, enter MISS_R.
  task automatic grant_ar(input logic [31:0] araddr);
    cyc();
    chk("ar_valid", mem_arvalid, 1'b1);
    chk("ar_addr", mem_araddr, araddr);
    mem_arready = 1'b1;
    cyc();
    mem_arready = 1'b0;
    #1;
    chk("r_ready", mem_rready, 1'b1);
  endtask

  initial begin
    rst_n         = 1'b0;
    ifu_req_valid = 1'b0;
    ifu_addr      = '0;
    ifu_flush     = 1'b0;
    mem_arready   = 1'b0;
    mem_rvalid    = 1'b0;
    mem_rdata     = '0;
    mem_rlast     = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", ifu_req_ready, 1'b1);
    chk("rst_rsp", ifu_rsp_valid, 1'b0);
    chk("rst_arvalid", mem_arvalid, 1'b0);
    chk("rst_rready", mem_rready, 1'b0);
    chk("rst_cen", line_CEN, 1'b1);
    chk("rst_wen", line_WEN, 1'b1);
    chk("rst_bwen", line_BWEN, {128{1'b1}});
    chk("rst_av", line_addr_valid, 1'b0);
`ifdef ICACHE_PERF_CNT_EN
    chk("rst_perf_hit", perf_hit_cnt, 32'd0);
    chk("rst_perf_miss", perf_miss_cnt, 32'd0);
`endif
    rst_n = 1'b1;
    cyc();

    // Cold miss on 0x8000_0004.
    fetch(32'h8000_0004, 6'd0);
    chk("cold_lookup_rsp", ifu_rsp_valid, 1'b0);
    grant_ar(32'h8000_0000);
    beat(32'h11, 1'b0, 1'b0);
    beat(32'h22, 1'b0, 1'b0);
    beat(32'h33, 1'b0, 1'b0);
    beat(32'h44, 1'b1, 1'b0);
    chk("cold_wen", line_WEN, 1'b0);
    chk("cold_cen", line_CEN, 1'b0);
    chk("cold_bwen", line_BWEN, 128'd0);
    chk("cold_d", line_D, {32'h44, 32'h33, 32'h22, 32'h11});
    chk("cold_a", line_A, 6'd0);
    chk("cold_tag", line_tag_in, 22'h20_0000);
    chk("cold_rsp_v", ifu_rsp_valid, 1'b1);
    chk("cold_rsp_d", ifu_rsp_data, 32'h22);
    chk("cold_rready", mem_rready, 1'b0);
    cyc();

    // Hit on word 3 of the same line: response two cycles after acceptance.
    fetch(32'h8000_000C, 6'd0);
    chk("hit_c1_rsp", ifu_rsp_valid, 1'b0);
    cyc();
    chk("hit_c2_rsp", ifu_rsp_valid, 1'b1);
    chk("hit_c2_data", ifu_rsp_data, 32'h44);
    chk("hit_c2_ar", mem_arvalid, 1'b0);
`ifdef ICACHE_PERF_CNT_EN
    chk("perf_hit1", perf_hit_cnt, 32'd1);
    chk("perf_miss1", perf_miss_cnt, 32'd1);
`endif
    cyc();
    chk("hit_c3_rsp", ifu_rsp_valid, 1'b0);
    chk("hit_c3_ar", mem_arvalid, 1'b0);

    // Tag conflict on index 0 with arready withheld for five cycles.
    fetch(32'h8000_0400, 6'd0);
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("stall_arvalid", mem_arvalid, 1'b1);
      chk("stall_araddr", mem_araddr, 32'h8000_0400);
      chk("stall_rready", mem_rready, 1'b0);
    end
    mem_arready = 1'b1;
    cyc();
    mem_arready = 1'b0;
    #1;
    chk("conf_rready", mem_rready, 1'b1);
    chk("conf_arvalid_drop", mem_arvalid, 1'b0);
    beat(32'hA0, 1'b0, 1'b0);
    beat(32'hA1, 1'b0, 1'b0);
    beat(32'hA2, 1'b0, 1'b0);
    beat(32'hA3, 1'b1, 1'b0);
    chk("conf_tag", line_tag_in, 22'h20_0001);
    chk("conf_d", line_D, {32'hA3, 32'hA2, 32'hA1, 32'hA0});
    chk("conf_rsp_d", ifu_rsp_data, 32'hA0);
    cyc();
    fetch(32'h8000_0408, 6'd0);
    cyc();
    chk("conf_hit_v", ifu_rsp_valid, 1'b1);
    chk("conf_hit_d", ifu_rsp_data, 32'hA2);
    cyc();

    // Flush during beat 2: line still written, no response, next fetch hits.
    fetch(32'h8000_0010, 6'd1);
    grant_ar(32'h8000_0010);
    beat(32'hB0, 1'b0, 1'b0);
    beat(32'hB1, 1'b0, 1'b0);
    beat(32'hB2, 1'b0, 1'b1);
    beat(32'hB3, 1'b1, 1'b0);
    chk("flush_rsp", ifu_rsp_valid, 1'b0);
    chk("flush_wen", line_WEN, 1'b0);
    chk("flush_d", line_D, {32'hB3, 32'hB2, 32'hB1, 32'hB0});
    cyc();
    chk("flush_idle_rsp", ifu_rsp_valid, 1'b0);
    fetch(32'h8000_0014, 6'd1);
    cyc();
    chk("flush_hit_v", ifu_rsp_valid, 1'b1);
    chk("flush_hit_d", ifu_rsp_data, 32'hB1);
    cyc();

    // Flush in LOOKUP on a cold line: no response and no burst.
    fetch(32'h8000_0030, 6'd3);
    ifu_flush = 1'b1;
    cyc();
    ifu_flush = 1'b0;
    #1;
    chk("lkflush_rsp", ifu_rsp_valid, 1'b0);
    chk("lkflush_ready", ifu_req_ready, 1'b1);
    cyc();
    chk("lkflush_ar", mem_arvalid, 1'b0);

    // Reset mid-burst.
    fetch(32'h8000_0020, 6'd2);
    grant_ar(32'h8000_0020);
    beat(32'hC0, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("mrst_rready", mem_rready, 1'b0);
    chk("mrst_cen", line_CEN, 1'b1);
    chk("mrst_ready", ifu_req_ready, 1'b1);
    chk("mrst_ar", mem_arvalid, 1'b0);
`ifdef ICACHE_PERF_CNT_EN
    chk("mrst_perf_hit", perf_hit_cnt, 32'd0);
    chk("mrst_perf_miss", perf_miss_cnt, 32'd0);
`endif
    cyc();
    rst_n = 1'b1;
    cyc();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
